// File: rtl/regfile_if.sv
// Read-request channel between the decode stage and the register file:
// two independent read ports, each with an enable/address and a data return.
interface i_fetch_rreg;
    typedef struct packed {
        logic       en;
        logic [4:0] addr;
    } rreg_info_t;

    rreg_info_t  r1_info;
    rreg_info_t  r2_info;
    logic [31:0] r1_data;
    logic [31:0] r2_data;

    modport master (
        output r1_info,
        output r2_info,
        input  r1_data,
        input  r2_data
    );

    modport slave (
        input  r1_info,
        input  r2_info,
        output r1_data,
        output r2_data
    );
endinterface

// File: rtl/regfile.sv
// 32x32 general-purpose register file with write-first bypass on both read ports.
// Optional HI/LO register pair is compiled in when REGFILE_HILO_EN is defined.
module regfile (
    input  logic        clk,
    input  logic        rst,
    i_fetch_rreg.slave  fetch,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
`ifdef REGFILE_HILO_EN
    input  logic        hilo_we,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
`endif
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    // GPR0 has no storage; it is hard-wired to zero on every read path.
    logic [31:0] gpr [1:31];
    logic        wb_fire;

    assign wb_fire = wb_en && (wb_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_fire) begin
            gpr[wb_addr] <= wb_data;
        end
    end

    // Each read port forwards the in-flight writeback so decode sees the newest value.
    always_comb begin
        fetch.r1_data = '0;
        if (!rst && fetch.r1_info.en && (fetch.r1_info.addr != 5'd0)) begin
            if (wb_fire && (wb_addr == fetch.r1_info.addr)) begin
                fetch.r1_data = wb_data;
            end else begin
                fetch.r1_data = gpr[fetch.r1_info.addr];
            end
        end
    end

    always_comb begin
        fetch.r2_data = '0;
        if (!rst && fetch.r2_info.en && (fetch.r2_info.addr != 5'd0)) begin
            if (wb_fire && (wb_addr == fetch.r2_info.addr)) begin
                fetch.r2_data = wb_data;
            end else begin
                fetch.r2_data = gpr[fetch.r2_info.addr];
            end
        end
    end

    always_comb begin
        dbg_data = '0;
        if (!rst && (dbg_addr != 5'd0)) begin
            dbg_data = gpr[dbg_addr];
        end
    end

`ifdef REGFILE_HILO_EN
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (hilo_we) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    // A write that reset will discard is not forwarded either.
    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (hilo_we && !rst) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
    end
`endif

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; HI/LO checks are built only
// when REGFILE_HILO_EN is defined.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`ifdef REGFILE_HILO_EN
    logic        hilo_we;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
`endif

    int total;
    int bad;

    i_fetch_rreg fetch_bus ();

    regfile dut (
        .clk      (clk),
        .rst      (rst),
        .fetch    (fetch_bus.slave),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
`ifdef REGFILE_HILO_EN
        .hilo_we  (hilo_we),
        .hi_i     (hi_i),
        .lo_i     (lo_i),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
`endif
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at the falling edge; checks happen shortly after, well before the rising edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drive_idle;
        wb_en = 1'b0;
        wb_addr = 5'd0;
        wb_data = 32'h0;
        dbg_addr = 5'd0;
        fetch_bus.r1_info = '0;
        fetch_bus.r2_info = '0;
`ifdef REGFILE_HILO_EN
        hilo_we = 1'b0;
        hi_i = 32'h0;
        lo_i = 32'h0;
`endif
    endtask

    task automatic set_reads(input logic e1, input logic [4:0] a1,
                             input logic e2, input logic [4:0] a2);
        fetch_bus.r1_info.en = e1;
        fetch_bus.r1_info.addr = a1;
        fetch_bus.r2_info.en = e2;
        fetch_bus.r2_info.addr = a2;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1;
        wb_addr = a;
        wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic test_reset;
        drive_idle();
        rst = 1'b1;
        wb_en = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'hCAFEF00D;
        set_reads(1'b1, 5'd5, 1'b1, 5'd5);
        settle();
        total++;
        if (fetch_bus.r1_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_bypass_r1 got=%h want=%h", fetch_bus.r1_data, 32'h0);
        end
        tick();
        tick();
        rst = 1'b0;
        wb_en = 1'b0;
        set_reads(1'b1, 5'd5, 1'b1, 5'd31);
        dbg_addr = 5'd5;
        settle();
        total++;
        if (fetch_bus.r1_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_r1_addr5 got=%h want=%h", fetch_bus.r1_data, 32'h0);
        end
        total++;
        if (fetch_bus.r2_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_r2_addr31 got=%h want=%h", fetch_bus.r2_data, 32'h0);
        end
        total++;
        if (dbg_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_write_ignored got=%h want=%h", dbg_data, 32'h0);
        end
    endtask

    task automatic test_write_read;
        drive_idle();
        do_write(5'd3, 32'hDEADBEEF);
        set_reads(1'b1, 5'd3, 1'b0, 5'd0);
        dbg_addr = 5'd3;
        settle();
        total++;
        if (fetch_bus.r1_data !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL write_read_r1 got=%h want=%h", fetch_bus.r1_data, 32'hDEADBEEF);
        end
        total++;
        if (dbg_data !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL write_read_dbg got=%h want=%h", dbg_data, 32'hDEADBEEF);
        end
    endtask

    task automatic test_bypass;
        drive_idle();
        do_write(5'd7, 32'h11111111);
        wb_en = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'h22222222;
        set_reads(1'b1, 5'd7, 1'b1, 5'd7);
        dbg_addr = 5'd7;
        settle();
        total++;
        if (fetch_bus.r1_data !== 32'h22222222) begin
            bad++;
            $display("[TB] FAIL bypass_r1 got=%h want=%h", fetch_bus.r1_data, 32'h22222222);
        end
        total++;
        if (fetch_bus.r2_data !== 32'h22222222) begin
            bad++;
            $display("[TB] FAIL bypass_r2 got=%h want=%h", fetch_bus.r2_data, 32'h22222222);
        end
        total++;
        if (dbg_data !== 32'h11111111) begin
            bad++;
            $display("[TB] FAIL bypass_dbg_old got=%h want=%h", dbg_data, 32'h11111111);
        end
        tick();
        wb_en = 1'b0;
        settle();
        total++;
        if (dbg_data !== 32'h22222222) begin
            bad++;
            $display("[TB] FAIL bypass_dbg_new got=%h want=%h", dbg_data, 32'h22222222);
        end
    endtask

    task automatic test_zero_reg;
        drive_idle();
        wb_en = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'hFFFFFFFF;
        set_reads(1'b1, 5'd0, 1'b1, 5'd0);
        settle();
        total++;
        if (fetch_bus.r1_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL zero_same_cycle_r1 got=%h want=%h", fetch_bus.r1_data, 32'h0);
        end
        total++;
        if (fetch_bus.r2_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL zero_same_cycle_r2 got=%h want=%h", fetch_bus.r2_data, 32'h0);
        end
        tick();
        wb_en = 1'b0;
        dbg_addr = 5'd0;
        settle();
        total++;
        if (fetch_bus.r1_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL zero_next_cycle_r1 got=%h want=%h", fetch_bus.r1_data, 32'h0);
        end
        total++;
        if (dbg_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL zero_dbg got=%h want=%h", dbg_data, 32'h0);
        end
    endtask

    task automatic test_disabled_port;
        drive_idle();
        do_write(5'd9, 32'h12345678);
        set_reads(1'b1, 5'd9, 1'b0, 5'd9);
        settle();
        total++;
        if (fetch_bus.r2_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL disabled_r2 got=%h want=%h", fetch_bus.r2_data, 32'h0);
        end
        total++;
        if (fetch_bus.r1_data !== 32'h12345678) begin
            bad++;
            $display("[TB] FAIL enabled_r1 got=%h want=%h", fetch_bus.r1_data, 32'h12345678);
        end
    endtask

    task automatic test_back_to_back;
        drive_idle();
        wb_en = 1'b1;
        wb_addr = 5'd10;
        wb_data = 32'hAAAA5555;
        set_reads(1'b1, 5'd3, 1'b1, 5'd10);
        dbg_addr = 5'd10;
        settle();
        total++;
        if (fetch_bus.r1_data !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL other_addr_old got=%h want=%h", fetch_bus.r1_data, 32'hDEADBEEF);
        end
        total++;
        if (dbg_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL dbg_before_write got=%h want=%h", dbg_data, 32'h0);
        end
        tick();
        wb_addr = 5'd3;
        wb_data = 32'h0BADF00D;
        settle();
        total++;
        if (fetch_bus.r2_data !== 32'hAAAA5555) begin
            bad++;
            $display("[TB] FAIL b2b_r2_prev got=%h want=%h", fetch_bus.r2_data, 32'hAAAA5555);
        end
        total++;
        if (fetch_bus.r1_data !== 32'h0BADF00D) begin
            bad++;
            $display("[TB] FAIL b2b_r1_bypass got=%h want=%h", fetch_bus.r1_data, 32'h0BADF00D);
        end
        tick();
        wb_en = 1'b0;
        settle();
        total++;
        if (fetch_bus.r1_data !== 32'h0BADF00D) begin
            bad++;
            $display("[TB] FAIL b2b_r1_stored got=%h want=%h", fetch_bus.r1_data, 32'h0BADF00D);
        end
    endtask

    task automatic test_reset_midop;
        logic [4:0] regs [5];
        regs[0] = 5'd3;
        regs[1] = 5'd7;
        regs[2] = 5'd9;
        regs[3] = 5'd10;
        regs[4] = 5'd12;
        drive_idle();
        rst = 1'b1;
        wb_en = 1'b1;
        wb_addr = 5'd12;
        wb_data = 32'h77777777;
        set_reads(1'b1, 5'd3, 1'b1, 5'd9);
        dbg_addr = 5'd7;
        settle();
        total++;
        if (fetch_bus.r1_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL midrst_r1 got=%h want=%h", fetch_bus.r1_data, 32'h0);
        end
        total++;
        if (dbg_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL midrst_dbg got=%h want=%h", dbg_data, 32'h0);
        end
        tick();
        rst = 1'b0;
        wb_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_reads(1'b1, regs[i], 1'b0, 5'd0);
            dbg_addr = regs[i];
            settle();
            total++;
            if (fetch_bus.r1_data !== 32'h0 || dbg_data !== 32'h0) begin
                bad++;
                $display("[TB] FAIL post_rst_reg%0d got r1=%h dbg=%h want=%h",
                         regs[i], fetch_bus.r1_data, dbg_data, 32'h0);
            end
        end
    endtask

`ifdef REGFILE_HILO_EN
    task automatic test_hilo;
        drive_idle();
        hilo_we = 1'b1;
        hi_i = 32'hA5A5A5A5;
        lo_i = 32'h5A5A5A5A;
        settle();
        total++;
        if (hi_o !== 32'hA5A5A5A5 || lo_o !== 32'h5A5A5A5A) begin
            bad++;
            $display("[TB] FAIL hilo_bypass got hi=%h lo=%h want hi=%h lo=%h",
                     hi_o, lo_o, 32'hA5A5A5A5, 32'h5A5A5A5A);
        end
        tick();
        hilo_we = 1'b0;
        hi_i = 32'h0;
        lo_i = 32'h0;
        settle();
        total++;
        if (hi_o !== 32'hA5A5A5A5 || lo_o !== 32'h5A5A5A5A) begin
            bad++;
            $display("[TB] FAIL hilo_hold got hi=%h lo=%h want hi=%h lo=%h",
                     hi_o, lo_o, 32'hA5A5A5A5, 32'h5A5A5A5A);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        total++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
            bad++;
            $display("[TB] FAIL hilo_reset got hi=%h lo=%h want hi=%h lo=%h",
                     hi_o, lo_o, 32'h0, 32'h0);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_disabled_port();
        test_back_to_back();
        test_reset_midop();
`ifdef REGFILE_HILO_EN
        test_hilo();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, rising-edge clock for all state.
REQ-002 The block SHALL have the port rst, input, 1 bit, reset; synchronous, active-high.
REQ-003 The block SHALL have the port fetch, i_fetch_rreg slave modport, carrying r1_info{en,addr[4:0]} and r2_info{en,addr[4:0]} as inputs and r1_data[31:0] and r2_data[31:0] as outputs; it is the responder to the decode stage's read requests.
REQ-004 The block SHALL have the port wb_en, input, 1 bit, writeback enable.
REQ-005 The block SHALL have the port wb_addr, input, 5 bits, writeback destination register.
REQ-006 The block SHALL have the port wb_data, input, 32 bits, writeback value.
REQ-007 The block SHALL have the port hilo_we, input, 1 bit, HI/LO write enable (present only with REGFILE_HILO_EN).
REQ-008 The block SHALL have the ports hi_i and lo_i, input, 32 bits each, HI/LO write values (present only with REGFILE_HILO_EN).
REQ-009 The block SHALL have the ports hi_o and lo_o, output, 32 bits each, current HI/LO values (present only with REGFILE_HILO_EN).
REQ-010 The block SHALL have the port dbg_addr, input, 5 bits, debug read address.
REQ-011 The block SHALL have the port dbg_data, output, 32 bits, debug read data, with no bypass.

Function
REQ-012 The block SHALL store 32 GPRs of 32 bits each; GPR0 reads 0 always, and writes to it are discarded.
REQ-013 Writes SHALL take effect on the clk rising edge when wb_en=1 and wb_addr!=0 and rst=0; the register updates in the same edge.
REQ-014 Read ports SHALL be combinational with zero-cycle latency: data is valid in the same cycle that rN_info is presented.
REQ-015 A read port with en=0 SHALL output 0.
REQ-016 A read port with en=1 and addr=0 SHALL output 0, even if wb_addr=0 with wb_en=1.
REQ-017 Write-first bypass: if en=1, addr!=0, wb_en=1 and wb_addr==addr, the port SHALL output wb_data rather than the stored value.
REQ-018 Both read ports SHALL be independent; when both request the same address, both return identical data, bypass included.
REQ-019 dbg_data SHALL return the stored GPR value, or 0 for address 0, with no writeback bypass.
REQ-020 At most one GPR write per cycle; simultaneous read and write of different addresses SHALL return the old value for the read.
REQ-021 While rst=1, r1_data, r2_data and dbg_data SHALL be 0 regardless of inputs.

Reset
REQ-022 On a clk edge with rst=1, all GPRs SHALL clear to 0, and HI/LO SHALL clear to 0 if present.
REQ-023 Writes presented (wb_en or hilo_we) during a cycle with rst=1 SHALL be ignored.
REQ-024 When rst asserts mid-operation, the state lost SHALL be total: the first cycle after rst deasserts reads 0 from every GPR not written since.

Configuration
REQ-025 The macro REGFILE_HILO_EN, when defined, SHALL compile in 32-bit HI and LO registers.
REQ-026 With REGFILE_HILO_EN defined, HI/LO SHALL update on the edge where hilo_we=1, and hi_o/lo_o SHALL bypass hi_i/lo_i when hilo_we=1 in the same cycle.
REQ-027 With REGFILE_HILO_EN undefined, the ports hilo_we, hi_i, hi_o, lo_i and lo_o SHALL be absent, and no HI/LO storage SHALL exist.

Verification
REQ-028 Reset check: rst=1 for 2 cycles, then read r1 addr 5 and r2 addr 31 with en=1 -> both return 0x00000000.
REQ-029 Write then read: wb_en=1, addr 3, data 0xDEADBEEF on cycle N, then read r1 addr 3 on cycle N+1 -> 0xDEADBEEF; dbg addr 3 -> 0xDEADBEEF.
REQ-030 Bypass: reg 7 = 0x11111111; same cycle wb_en=1, addr 7, 0x22222222, with r1 and r2 addr 7 -> both 0x22222222, while dbg addr 7 -> 0x11111111.
REQ-031 Zero register: wb_en=1, addr 0, data 0xFFFFFFFF, with r1 addr 0 the same cycle and the next -> 0 both cycles.
REQ-032 Disabled port: reg 9 = 0x12345678, r2 en=0, addr 9 -> r2_data=0; r1 en=1, addr 9 -> 0x12345678.
REQ-033 HI/LO (macro defined): hilo_we=1, hi_i=0xA5A5A5A5, lo_i=0x5A5A5A5A -> hi_o/lo_o show these values the same cycle and hold after hilo_we drops; rst=1 for one edge -> both 0.
